// File: rtl/btn_pkg.sv
// rtl/btn_pkg.sv - shared channel indices and paddle direction codes for btn_cond
package btn_pkg;

    localparam int BTN_P1_UP  = 0;
    localparam int BTN_P1_DN  = 1;
    localparam int BTN_P1_SRV = 2;
    localparam int BTN_P2_UP  = 3;
    localparam int BTN_P2_DN  = 4;
    localparam int BTN_P2_SRV = 5;

    localparam logic [1:0] DIR_NONE = 2'b00;
    localparam logic [1:0] DIR_UP   = 2'b01;
    localparam logic [1:0] DIR_DN   = 2'b11;

    // Opposing presses cancel so a player mashing both buttons holds still.
    function automatic logic [1:0] dir_code(input logic up, input logic dn);
        logic [1:0] code;
        code = DIR_NONE;
        if (up && !dn) begin
            code = DIR_UP;
        end else if (dn && !up) begin
            code = DIR_DN;
        end
        return code;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - one button channel: 2-flop synchroniser, debounce counter, edge pulses
module btn_debounce #(
    parameter int DB_CYCLES = 65536,
    parameter int CNT_W     = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic lvl,
    output logic rise,
    output logic fall
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

    logic             sync_q1;
    logic             sync_q2;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
            cnt     <= '0;
            lvl     <= 1'b0;
            rise    <= 1'b0;
            fall    <= 1'b0;
        end else begin
            sync_q1 <= raw;
            sync_q2 <= sync_q1;
            rise    <= 1'b0;
            fall    <= 1'b0;
            // Any sample agreeing with the accepted level restarts the count.
            if (sync_q2 == lvl) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                lvl  <= sync_q2;
                cnt  <= '0;
                rise <= sync_q2;
                fall <= ~sync_q2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/btn_cond.sv
// rtl/btn_cond.sv - pong button conditioner: debounced levels, edge pulses, frame-latched dirs, serve requests
module btn_cond
    import btn_pkg::*;
#(
    parameter int N_BTN     = 6,
    parameter int DB_CYCLES = 65536,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_raw,
    input  logic             frame_stb,
    output logic [N_BTN-1:0] btn_lvl,
    output logic [N_BTN-1:0] btn_rise,
    output logic [N_BTN-1:0] btn_fall,
    output logic [1:0]       p1_dir,
    output logic [1:0]       p2_dir,
    output logic [1:0]       srv_pend,
    input  logic [1:0]       srv_ack
);

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        btn_debounce #(
            .DB_CYCLES (DB_CYCLES),
            .CNT_W     (CNT_W)
        ) u_db (
            .clk  (clk),
            .rst  (rst),
            .raw  (btn_raw[i]),
            .lvl  (btn_lvl[i]),
            .rise (btn_rise[i]),
            .fall (btn_fall[i])
        );
    end

    logic [1:0] srv_rise;
    assign srv_rise = {btn_rise[BTN_P2_SRV], btn_rise[BTN_P1_SRV]};

    // Uses the registered btn_lvl, so a strobe on a level-change cycle sees the old level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p1_dir <= DIR_NONE;
            p2_dir <= DIR_NONE;
        end else if (frame_stb) begin
            p1_dir <= dir_code(btn_lvl[BTN_P1_UP], btn_lvl[BTN_P1_DN]);
            p2_dir <= dir_code(btn_lvl[BTN_P2_UP], btn_lvl[BTN_P2_DN]);
        end
    end

    // A new press outranks a same-cycle ack so it is never dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            srv_pend <= 2'b00;
        end else begin
            srv_pend <= srv_rise | (srv_pend & ~srv_ack);
        end
    end

endmodule
